seg7_blink_monitor: RTL and testbench

- Receive-side checker for the team's active-low 7-segment digit driver with blink. It samples the 7-bit segment bus and decodes it back to a hex nibble.
- It classifies each sample as dark, lit-legal or illegal, and measures dark/lit run lengths to flag a correct blink cadence.
- It is used in benches and on-chip self-test to close the loop on display drivers. It must match the driver's encoding and its toggle interval of GAP+1 cycles.

---
 rtl/seg7_blink_monitor.sv | 109 ++++++++++
 tb/tb_seg7_blink_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_blink_monitor.sv
// Receive-side checker for the active-low 7-segment driver: decodes the bus back
// to a hex nibble, classifies each sample and detects a regular blink cadence.
module seg7_blink_monitor #(
    parameter int unsigned GAP   = 1000000,
    parameter int unsigned TOL   = 4096,
    parameter int unsigned CNT_W = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid,
    output logic       dark,
    output logic       bad_pattern,
    output logic       blinking
);

    localparam int unsigned HI_I = GAP + 1 + TOL;
    localparam int unsigned LO_I = (TOL >= GAP + 1) ? 1 : GAP + 1 - TOL;
    localparam logic [CNT_W:0] HI = (CNT_W + 1)'(HI_I);
    localparam logic [CNT_W:0] LO = (CNT_W + 1)'(LO_I);

    typedef enum logic [1:0] {STEADY, CAND, BLINK} state_t;
    typedef enum logic {LIT, DARK} class_t;

    state_t           state, state_nxt;
    class_t           last_cls, cur_cls;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   run_len;
    logic             change, good, timeout;
    logic             legal, is_dark;
    logic [3:0]       nib;

    always_comb begin
        legal = 1'b1;
        nib   = '0;
        case (seg)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h58: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    // Run length is counter+1 in one extra bit so a saturated counter cannot wrap.
    always_comb begin
        is_dark = (seg == 7'h7F);
        cur_cls = is_dark ? DARK : LIT;
        change  = (cur_cls != last_cls);
        run_len = {1'b0, cnt} + (CNT_W + 1)'(1);
        good    = (run_len >= LO) && (run_len <= HI);
        timeout = !change && (run_len > HI);
    end

    always_comb begin
        state_nxt = state;
        if (change) begin
            if (!good)
                state_nxt = STEADY;
            else if (state == STEADY)
                state_nxt = CAND;
            else
                state_nxt = BLINK;
        end else if (timeout) begin
            state_nxt = STEADY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= STEADY;
            last_cls    <= LIT;
            cnt         <= '0;
            digit       <= '0;
            valid       <= 1'b0;
            dark        <= 1'b0;
            bad_pattern <= 1'b0;
            blinking    <= 1'b0;
        end else begin
            state       <= state_nxt;
            blinking    <= (state == BLINK);
            valid       <= legal;
            dark        <= is_dark;
            bad_pattern <= !legal && !is_dark;
            if (legal)
                digit <= nib;
            if (change) begin
                cnt      <= '0;
                last_cls <= cur_cls;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_blink_monitor.sv
// Directed bench for seg7_blink_monitor (GAP=20, TOL=2: window 19..23) with a
// reference-model scoreboard plus explicit cadence milestones.
module tb_seg7_blink_monitor;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] digit;
    logic       valid, dark, bad_pattern, blinking;

    seg7_blink_monitor #(.GAP(20), .TOL(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .digit(digit), .valid(valid),
        .dark(dark), .bad_pattern(bad_pattern), .blinking(blinking)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic       v, dk, bp, bl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference cadence model: m_run = samples seen so far in the current run.
    int         m_run;
    bit         m_last_dark;
    int         m_state;   // 0 steady, 1 candidate, 2 blink
    logic [3:0] m_digit;

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++)
            if (codes[i] == s) return i;
        return -1;
    endfunction

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_run       = 1;
        m_last_dark = 1'b0;
        m_state     = 0;
        m_digit     = 4'h0;
    endtask

    task automatic drive(input logic [6:0] s);
        exp_t e;
        exp_t got;
        int   idx;
        bit   dk;
        @(negedge clk);
        seg = s;
        idx = lookup(s);
        dk  = (s == 7'h7F);
        if (idx >= 0) m_digit = 4'(idx);
        e.d  = m_digit;
        e.v  = (idx >= 0);
        e.dk = dk;
        e.bp = (idx < 0) && !dk;
        e.bl = (m_state == 2);
        if (dk != m_last_dark) begin
            if (m_run >= 19 && m_run <= 23)
                m_state = (m_state == 0) ? 1 : 2;
            else
                m_state = 0;
            m_run       = 1;
            m_last_dark = dk;
        end else begin
            if (m_run > 23) m_state = 0;
            m_run++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        total++;
        assert (q.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", q.size());
        end
        if (q.size() > 0) begin
            got = q.pop_front();
            chk4("sb_digit", digit, got.d);
            chk1("sb_valid", valid, got.v);
            chk1("sb_dark", dark, got.dk);
            chk1("sb_bad_pattern", bad_pattern, got.bp);
            chk1("sb_blinking", blinking, got.bl);
        end
    endtask

    task automatic run(input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) drive(s);
    endtask

    task automatic reset_pulse(input logic [6:0] s);
        @(negedge clk);
        rst_n = 1'b0;
        seg   = s;
        @(posedge clk);
        #1;
        model_reset();
        chk4("rst_digit", digit, 4'h0);
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_dark", dark, 1'b0);
        chk1("rst_bad_pattern", bad_pattern, 1'b0);
        chk1("rst_blinking", blinking, 1'b0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        seg   = 7'h7F;
        model_reset();
        reset_pulse(7'h7F);

        drive(7'h40);
        chk4("first_digit", digit, 4'h0);
        chk1("first_valid", valid, 1'b1);

        for (int i = 0; i < 16; i++) begin
            drive(codes[i]);
            chk4("sweep_digit", digit, 4'(i));
            chk1("sweep_valid", valid, 1'b1);
        end

        drive(7'h12);
        drive(7'h3F);
        chk1("illegal_bad", bad_pattern, 1'b1);
        chk1("illegal_valid", valid, 1'b0);
        chk4("illegal_digit_hold", digit, 4'h5);
        drive(7'h7F);
        chk1("dark_flag", dark, 1'b1);
        chk1("dark_bad_clear", bad_pattern, 1'b0);
        chk4("dark_digit_hold", digit, 4'h5);

        // Clean cadence from reset: BLINK entered at sample 43, visible at 44.
        reset_pulse(7'h7F);
        run(7'h7F, 21);
        run(7'h40, 21);
        run(7'h7F, 1);
        chk1("blink_not_yet", blinking, 1'b0);
        run(7'h7F, 1);
        chk1("blink_rise", blinking, 1'b1);
        run(7'h7F, 19);
        for (int i = 0; i < 10; i++) run((i % 2 == 0) ? 7'h40 : 7'h7F, 21);
        chk1("blink_hold_21", blinking, 1'b1);
        for (int i = 0; i < 4; i++) run((i % 2 == 0) ? 7'h40 : 7'h7F, 22);
        chk1("blink_hold_22", blinking, 1'b1);

        run(7'h40, 25);
        chk1("timeout_edge", blinking, 1'b1);
        run(7'h40, 1);
        chk1("timeout_drop", blinking, 1'b0);
        run(7'h40, 4);

        run(7'h7F, 21);
        run(7'h40, 21);
        run(7'h7F, 21);
        run(7'h40, 21);
        chk1("reblink", blinking, 1'b1);
        run(7'h7F, 17);
        run(7'h40, 17);
        run(7'h7F, 17);
        run(7'h40, 17);
        chk1("short_drop", blinking, 1'b0);

        run(7'h7F, 21);
        run(7'h40, 21);
        run(7'h7F, 21);
        run(7'h40, 5);
        chk1("pre_reset_blink", blinking, 1'b1);
        reset_pulse(7'h40);
        run(7'h7F, 21);
        run(7'h40, 21);
        run(7'h7F, 1);
        chk1("post_reset_wait", blinking, 1'b0);
        run(7'h7F, 1);
        chk1("post_reset_blink", blinking, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
